// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning matrix keypad with whole-scan debounce and multi-key rejection.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while the accepted key stays held.
module keypad_scanner #(
  parameter int NUM_ROWS           = 4,
  parameter int NUM_COLS           = 4,
  parameter int SCAN_DIV           = 100000,
  parameter int SETTLE             = 8,
  parameter int DEBOUNCE_SCANS     = 3,
  parameter int REPEAT_DELAY_SCANS = 32,
  parameter int REPEAT_RATE_SCANS  = 8,
  localparam int KW = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KW-1:0]       key_code,
  output logic                key_valid,
  output logic                key_held,
  output logic                multi_key
);
  localparam int CW = $clog2(NUM_COLS);
  localparam int NW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS+1);
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, HOLD, EVAL} state_t;
  typedef enum logic [1:0] {R_NONE, R_KEY, R_MULTI} res_t;
  state_t state_q, state_d;
  res_t prev_q, prev_d, res;
  logic [NUM_ROWS-1:0] sync1_q, sync2_q;
  logic [CW-1:0] col_q, col_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [1:0] hits_q, hits_d, col_hits;
  logic [KW-1:0] idx_q, idx_d, col_idx, prev_idx_q, prev_idx_d, code_q, code_d;
  logic [SW-1:0] stab_q, stab_d, stab_n;
  logic held_q, held_d, valid_q, valid_d, multi_q, multi_d;
  logic same, stable, accept_key;
`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_SCANS+REPEAT_RATE_SCANS+1);
  logic [RW-1:0] rep_q, rep_d, rep_n;
  logic rate_q, rate_d;
  assign rep_n = rep_q + RW'(1);
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY_SCANS, REPEAT_RATE_SCANS};
`endif
  assign col_n     = (state_q == IDLE) ? '1 : ~(NUM_COLS'(1) << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign multi_key = multi_q;
  // hit count saturates at 2: anything beyond one active row is already MULTI
  always_comb begin
    col_hits = 2'd0;
    col_idx  = '0;
    for (int r = 0; r < NUM_ROWS; r++)
      if (!sync2_q[r]) begin
        col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
        col_idx  = KW'(r*NUM_COLS + int'(col_q));
      end
  end
  assign res        = (hits_q == 2'd0) ? R_NONE : (hits_q == 2'd1) ? R_KEY : R_MULTI;
  assign same       = (res == prev_q) && (res != R_KEY || idx_q == prev_idx_q);
  assign stab_n     = !same ? SW'(1) : (stab_q == SW'(DEBOUNCE_SCANS)) ? stab_q : stab_q + SW'(1);
  assign stable     = stab_n == SW'(DEBOUNCE_SCANS);
  assign accept_key = stable && res == R_KEY && (!held_q || idx_q != code_q);
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cnt_d      = cnt_q + NW'(1);
    hits_d     = hits_q;
    idx_d      = idx_q;
    prev_d     = prev_q;
    prev_idx_d = prev_idx_q;
    stab_d     = stab_q;
    code_d     = code_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    multi_d    = multi_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d      = rep_q;
    rate_d     = rate_q;
`endif
    case (state_q)
      DRIVE:  state_d = (cnt_q == NW'(SETTLE-1)) ? SAMPLE : DRIVE;
      SAMPLE: begin
        state_d = HOLD;
        hits_d  = (hits_q == 2'd0) ? col_hits : (col_hits == 2'd0) ? hits_q : 2'd2;
        idx_d   = (hits_q == 2'd0) ? col_idx : idx_q;
      end
      HOLD: if (cnt_q == NW'(SCAN_DIV-1)) begin
        cnt_d   = '0;
        state_d = (col_q == CW'(NUM_COLS-1)) ? EVAL : DRIVE;
        col_d   = (col_q == CW'(NUM_COLS-1)) ? col_q : col_q + CW'(1);
      end
      EVAL: begin
        state_d    = DRIVE;
        col_d      = '0;
        cnt_d      = '0;
        hits_d     = 2'd0;
        prev_d     = res;
        prev_idx_d = idx_q;
        stab_d     = stab_n;
        multi_d    = res == R_MULTI;
        code_d     = accept_key ? idx_q : code_q;
        held_d     = accept_key ? 1'b1 : (stable && res == R_NONE) ? 1'b0 : held_q;
        valid_d    = accept_key;
`ifdef KEYPAD_REPEAT_EN
        // repeats count only scans that still show exactly the accepted key
        if (accept_key || res != R_KEY || idx_q != code_q || !held_q) begin
          rep_d  = '0;
          rate_d = 1'b0;
        end else if (rep_n == (rate_q ? RW'(REPEAT_RATE_SCANS) : RW'(REPEAT_DELAY_SCANS))) begin
          rep_d   = '0;
          rate_d  = 1'b1;
          valid_d = 1'b1;
        end else
          rep_d = rep_n;
`endif
      end
      default: begin
        state_d = DRIVE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      state_q    <= IDLE;
      col_q      <= '0;
      cnt_q      <= '0;
      hits_q     <= 2'd0;
      idx_q      <= '0;
      prev_q     <= R_NONE;
      prev_idx_q <= '0;
      stab_q     <= '0;
      code_q     <= '0;
      held_q     <= 1'b0;
      valid_q    <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      sync1_q    <= row_n;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      hits_q     <= hits_d;
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      prev_idx_q <= prev_idx_d;
      stab_q     <= stab_d;
      code_q     <= code_d;
      held_q     <= held_d;
      valid_q    <= valid_d;
      multi_q    <= multi_d;
    end
`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_q  <= '0;
      rate_q <= 1'b0;
    end else begin
      rep_q  <= rep_d;
      rate_q <= rate_d;
    end
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed scan-aligned checks of keypad_scanner on a 4x4 matrix model.
// Checkpoints sit on the falling edge in the first cycle of each scan, right after an EVAL.
module tb_keypad_scanner;
  localparam int SCAN = 65;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 1;
`else
  localparam int REP = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] pressed = '0;
  logic [3:0] row_n, col_n, key_code, e;
  logic key_valid, key_held, multi_key;
  int compared = 0;
  int mismatched = 0;
  int pulses = 0;
  int base;
  keypad_scanner #(
    .NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(16), .SETTLE(4), .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY_SCANS(4), .REPEAT_RATE_SCANS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end
  always @(posedge clk) if (key_valid) pulses <= pulses + 1;
  task automatic check(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input int v, input int h, input int code);
    check({tag, ".valid"}, key_valid, v);
    check({tag, ".held"}, key_held, h);
    check({tag, ".code"}, key_code, code);
  endtask
  task automatic scans(input int n);
    repeat (n*SCAN) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst.col_n", col_n, 4'hF);
    outs("rst", 0, 0, 0);
    check("rst.multi", multi_key, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= SCAN; c++) begin
      e = (c == SCAN) ? 4'h7 : ~(4'b0001 << ((c-1)/16));
      check($sformatf("col_n.c%0d", c), col_n, e);
      @(negedge clk);
    end
    scans(9);
    outs("idle", 0, 0, 0);
    check("idle.multi", multi_key, 0);
    check("idle.pulses", pulses, 0);
    base = pulses;
    pressed = 16'h0200;
    scans(2);
    outs("k9.s2", 0, 0, 0);
    scans(1);
    outs("k9.s3", 1, 1, 9);
    scans(2);
    check("k9.pulses", pulses - base, 1);
    pressed = '0;
    scans(2);
    outs("rel.s2", 0, 1, 9);
    scans(1);
    outs("rel.s3", 0, 0, 9);
    check("rel.pulses", pulses - base, 1);
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
      scans(1);
    end
    scans(1);
    outs("bnc.s2", 0, 0, 9);
    check("bnc.early", pulses - base, 0);
    scans(1);
    outs("bnc.s3", 1, 1, 9);
    scans(2);
    check("bnc.pulses", pulses - base, 1);
    base = pulses;
    pressed = 16'h0021;
    scans(1);
    outs("multi", 0, 1, 9);
    check("multi.flag", multi_key, 1);
    pressed = 16'h0001;
    scans(1);
    check("multi.clr", multi_key, 0);
    check("multi.held", key_held, 1);
    scans(1);
    outs("k0.s2", 0, 1, 9);
    scans(1);
    outs("k0.s3", 1, 1, 0);
    check("multi.pulses", pulses - base, 0);
    pressed = 16'h0008;
    scans(3);
    outs("k3", 1, 1, 3);
    pressed = 16'h1000;
    scans(1);
    outs("roll.s1", 0, 1, 3);
    base = pulses;
    scans(1);
    outs("roll.s2", 0, 1, 3);
    scans(1);
    outs("roll.s3", 1, 1, 12);
    check("roll.pulses", pulses - base, 0);
    pressed = 16'h0080;
    scans(3);
    outs("k7", 1, 1, 7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid.col_n", col_n, 4'hF);
    outs("mid", 0, 0, 0);
    check("mid.multi", multi_key, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    scans(2);
    outs("re7.s2", 0, 0, 0);
    check("re7.multi", multi_key, 0);
    scans(1);
    outs("re7.s3", 1, 1, 7);
    scans(1);
    base = pulses;
    scans(3);
    outs("rep.s7", REP, 1, 7);
    scans(3);
    check("rep.pulses", pulses - base, 2*REP);
    pressed = '0;
    scans(3);
    outs("rel7", 0, 0, 7);
    scans(1);
    check("rel7.pulses", pulses - base, 2*REP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
